// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, and
// reports the parallel difference, final borrow and signed overflow.
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             diff_bit,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_reg;
   state_t           state_next;
   logic [WIDTH-1:0] a_sr_reg;
   logic [WIDTH-1:0] b_sr_reg;
   logic [WIDTH-1:0] res_sr_reg;
   logic [CW-1:0]    cnt_reg;
   logic             brw_reg;
   logic             brw_next;
   logic             a_msb_reg;
   logic             b_msb_reg;
   logic             sum_bit;
   logic             last_bit;

   assign sum_bit  = a_sr_reg[0] ^ b_sr_reg[0] ^ brw_reg;
   assign brw_next = (~a_sr_reg[0] & b_sr_reg[0]) | (~(a_sr_reg[0] ^ b_sr_reg[0]) & brw_reg);
   assign last_bit = (cnt_reg == CW'(WIDTH - 1));

   assign busy     = (state_reg == SHIFT);
   assign done     = (state_reg == DONE);
   assign diff_bit = busy & sum_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = SHIFT;
         SHIFT:   if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr_reg   <= '0;
         b_sr_reg   <= '0;
         res_sr_reg <= '0;
         cnt_reg    <= '0;
         brw_reg    <= 1'b0;
         a_msb_reg  <= 1'b0;
         b_msb_reg  <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  a_sr_reg  <= a;
                  b_sr_reg  <= b;
                  cnt_reg   <= '0;
                  brw_reg   <= 1'b0;
                  a_msb_reg <= a[WIDTH-1];
                  b_msb_reg <= b[WIDTH-1];
               end
            end
            SHIFT: begin
               a_sr_reg   <= a_sr_reg >> 1;
               b_sr_reg   <= b_sr_reg >> 1;
               res_sr_reg <= {sum_bit, res_sr_reg[WIDTH-1:1]};
               brw_reg    <= brw_next;
               cnt_reg    <= cnt_reg + CW'(1);
               // The bit produced in the final cycle is the result MSB.
               if (last_bit) begin
                  diff       <= {sum_bit, res_sr_reg[WIDTH-1:1]};
                  borrow_out <= brw_next;
                  overflow   <= (a_msb_reg != b_msb_reg) && (sum_bit != a_msb_reg);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed scenarios plus random
// operands checked against an arithmetic reference model.
module tb_serial_subtractor;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         diff_bit;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         overflow;

   int compared   = 0;
   int mismatched = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .diff_bit   (diff_bit),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out),
      .overflow   (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One operation from IDLE; optional re-pulse of start or reset mid-shift.
   task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input int repulse_at, input int reset_at);
      logic [W-1:0] exp_diff;
      logic         exp_brw;
      logic         exp_ovf;
      int           sd;
      exp_diff = av - bv;
      exp_brw  = (av < bv);
      sd       = int'($signed(av)) - int'($signed(bv));
      exp_ovf  = (sd > (2 ** (W - 1)) - 1) || (sd < -(2 ** (W - 1)));

      check("idle_busy", busy, 1'b0);
      a = av;
      b = bv;
      start = 1'b1;
      @(negedge clk);
      for (int i = 0; i < W; i++) begin
         if (i == reset_at) begin
            rst_n = 1'b0;
            #1;
            check("rst_busy", busy, 1'b0);
            check("rst_diff", diff, '0);
            check("rst_done", done, 1'b0);
            check("rst_diff_bit", diff_bit, 1'b0);
            check("rst_borrow", borrow_out, 1'b0);
            check("rst_ovf", overflow, 1'b0);
            start = 1'b0;
            repeat (2) @(negedge clk);
            check("rst_hold_done", done, 1'b0);
            check("rst_hold_busy", busy, 1'b0);
            rst_n = 1'b1;
            $display("op a=%0d b=%0d aborted by reset at shift cycle %0d", av, bv, i);
            return;
         end
         check($sformatf("busy[%0d]", i), busy, 1'b1);
         check($sformatf("done_early[%0d]", i), done, 1'b0);
         check($sformatf("bit[%0d]", i), diff_bit, exp_diff[i]);
         if (i == repulse_at) begin
            start = 1'b1;
            a = '1;
            b = '0;
         end else begin
            start = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("done", done, 1'b1);
      check("done_busy", busy, 1'b0);
      check("done_diff_bit", diff_bit, 1'b0);
      check("diff", diff, exp_diff);
      check("borrow", borrow_out, exp_brw);
      check("ovf", overflow, exp_ovf);
      @(negedge clk);
      check("after_done", done, 1'b0);
      check("after_busy", busy, 1'b0);
      check("diff_hold", diff, exp_diff);
      $display("op a=0x%0h b=0x%0h -> diff=0x%0h borrow=%0b ovf=%0b", av, bv, diff, borrow_out, overflow);
   endtask

   initial begin
      int last_done;
      int pulses;
      rst_n = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      #2 rst_n = 1'b0;
      #1;
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      check("reset_diff_bit", diff_bit, 1'b0);
      check("reset_diff", diff, '0);
      check("reset_borrow", borrow_out, 1'b0);
      check("reset_ovf", overflow, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_op(8'd100, 8'd58, -1, -1);
      check("c100_58", diff, 8'h2A);
      run_op(8'd5, 8'd10, -1, -1);
      check("c5_10", {borrow_out, overflow, diff}, {2'b10, 8'hFB});
      run_op(8'h80, 8'h01, -1, -1);
      check("c80_01", {borrow_out, overflow, diff}, {2'b01, 8'h7F});
      run_op(8'h7F, 8'hFF, -1, -1);
      check("c7f_ff", {borrow_out, overflow, diff}, {2'b11, 8'h80});

      run_op(8'd100, 8'd58, 3, -1);
      check("repulse_result", diff, 8'h2A);

      run_op(8'd100, 8'd58, -1, 2);
      run_op(8'd0, 8'd0, -1, -1);
      check("after_reset_zero", {borrow_out, diff}, 9'h000);

      // Start held high: one result every WIDTH+2 cycles.
      a = 8'd3;
      b = 8'd1;
      start = 1'b1;
      last_done = -1;
      pulses = 0;
      for (int c = 0; c < 45; c++) begin
         @(negedge clk);
         if (done) begin
            check("cont_diff", diff, 8'h02);
            if (last_done >= 0) check("cont_period", c - last_done, 10);
            $display("continuous done pulse at cycle %0d diff=0x%0h", c, diff);
            last_done = c;
            pulses++;
         end
      end
      start = 1'b0;
      check("cont_pulses", pulses, 4);
      repeat (12) @(negedge clk);
      check("cont_idle", busy, 1'b0);

      for (int n = 0; n < 30; n++) begin
         run_op(W'($urandom), W'($urandom), -1, -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
